memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
Shares the MemoryManager CPU-side pixel port (memoryXCoord/memoryYCoord/memoryRead/WriteRequest/memoryWriteData/completes) between NUM_REQUESTERS independent clients, e.g. host bus bridge and fill/blit engine.
Sits directly in front of MemoryManager and owns the request/complete handshake.
Clients issue single-pixel reads or writes; the block grants round-robin, holds the MemoryManager request until completion, and returns read data plus a one-cycle done pulse.
A watchdog aborts any transaction that never completes.

Parameters:
NUM_REQUESTERS, 2, number of clients (2..4).
TIMEOUT_CYCLES, 64, cycles in BUSY before abort (>= 8, since one MemoryManager frame is 5 cycles).

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
requestValid  input  NUM_REQUESTERS  per-client request, held until matching requestDone.
requestWrite  input  NUM_REQUESTERS  1 = write, 0 = read.
requestXCoord  input  NUM_REQUESTERS x 9  pixel X, 0..319.
requestYCoord  input  NUM_REQUESTERS x 8  pixel Y, 0..239.
requestWriteData  input  NUM_REQUESTERS x 8  write byte.
requestDone  output  NUM_REQUESTERS  one-cycle pulse to the granted client.
requestError  output  1  valid with requestDone; 1 = timed out.
requestReadData  output  8  read byte; valid with requestDone; held until the next done.
memoryXCoord  output  9  to MemoryManager.
memoryYCoord  output  8  to MemoryManager.
memoryReadRequest  output  1  to MemoryManager.
memoryWriteRequest  output  1  to MemoryManager.
memoryWriteData  output  8  to MemoryManager.
memoryReadData  input  8  from MemoryManager.
memoryReadComplete  input  1  from MemoryManager.
memoryWriteComplete  input  1  from MemoryManager.

Behaviour:
- Reset (reset==0, async): state IDLE; all outputs 0; lastGrant = NUM_REQUESTERS-1, so client 0 wins first; watchdog 0.
- FSM states: IDLE, BUSY, RECOVER.
- IDLE: if any requestValid, pick the first set bit scanning from lastGrant+1 (mod NUM_REQUESTERS). At the edge:
  - latch grant index, op, coords and data into memoryXCoord/memoryYCoord/memoryWriteData;
  - assert memoryWriteRequest or memoryReadRequest (never both);
  - go to BUSY with watchdog cleared.
- BUSY: request and address/data are held stable. Only the completion matching the latched op counts; a mismatched complete is ignored. When the matching complete is sampled high at an edge:
  - drop memory*Request;
  - on a read, capture memoryReadData into requestReadData;
  - pulse requestDone[grant] with requestError=0;
  - set lastGrant = grant;
  - go to RECOVER.
- Watchdog: increments each BUSY cycle. If it reaches TIMEOUT_CYCLES-1 with no complete, the block drops the request, pulses requestDone[grant] with requestError=1, leaves requestReadData unchanged, and goes to RECOVER.
- Complete and timeout on the same edge: complete wins, so requestError=0.
- RECOVER: one cycle with both requests low. This guarantees MemoryManager samples no stale request in its next VIDEO_READ slot. Then go to IDLE.
- Latency: valid high in IDLE at edge N -> memory request high after N -> done pulse on the cycle after the complete edge.
- Minimum turnaround per transaction is completion + 2 cycles.
- Client rules:
  - requestValid is sampled only in IDLE.
  - Inputs are captured at grant; later changes have no effect on the current transaction.
  - Deasserting valid while granted does not cancel the transaction; the done pulse is still issued.
  - Valid still high in the IDLE after done counts as a new request, arbitrated fairly.
- Coordinates are passed through unchecked (no range clamping).
- Reset asserted mid-BUSY: requests drop immediately (async) and no done is issued. Clients must treat reset as cancellation.

Decomposition:
- Shared package (memory_port_pkg):
  - arbiter state enum {IDLE, BUSY, RECOVER};
  - X_WIDTH=9, Y_WIDTH=8, DATA_WIDTH=8;
  - SCREEN_WIDTH=320, SCREEN_HEIGHT=240.
- One sub-module, round_robin_picker: combinational, takes valid vector and lastGrant, returns grant index and anyValid.
- FSM, watchdog and datapath latches live in the top.

Test Plan:
1. Client0 writes x=5,y=7,data=0xA5 against a MemoryManager model -> memoryWriteRequest high with coords 5/7 until memoryWriteComplete; requestDone[0] one cycle later; error=0; RAM[{7,5}]==0xA5.
2. Client1 reads x=319,y=239 with RAM=0x3C -> memoryReadRequest only; requestReadData=0x3C with requestDone[1]; memoryWriteRequest stays 0.
3. Both clients hold valid continuously for 8 transactions -> grants alternate 0,1,0,1…; each gets exactly 4 dones; RECOVER gap of 1 cycle between each.
4. Model never completes, TIMEOUT_CYCLES=16 -> request drops and requestDone/requestError=1 exactly 15 cycles after BUSY entry; next request served normally.
5. memoryWriteComplete pulsed during a read, then memoryReadComplete -> spurious pulse ignored; done only on the read complete.
6. reset driven low mid-BUSY -> request outputs 0 asynchronously, no done; after release client 0 is granted first.

Source files
------------

// File: rtl/memory_port_pkg.sv
// ============================================================================
// memory_port_pkg : shared types and widths for the MemoryManager pixel port
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_port_pkg;

    localparam int X_WIDTH       = 9;
    localparam int Y_WIDTH       = 8;
    localparam int DATA_WIDTH    = 8;
    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/memory_port_arbiter_if.sv
// ============================================================================
// memory_port_arbiter_if : client request bus plus MemoryManager pixel port
// Revision: 1.0
// ============================================================================
`default_nettype none

interface memory_port_arbiter_if #(
    parameter int NUM_REQUESTERS = 2
);
    import memory_port_pkg::*;

    logic [NUM_REQUESTERS-1:0]                 requestValid;
    logic [NUM_REQUESTERS-1:0]                 requestWrite;
    logic [NUM_REQUESTERS-1:0][X_WIDTH-1:0]    requestXCoord;
    logic [NUM_REQUESTERS-1:0][Y_WIDTH-1:0]    requestYCoord;
    logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] requestWriteData;
    logic [NUM_REQUESTERS-1:0]                 requestDone;
    logic                                      requestError;
    logic [DATA_WIDTH-1:0]                     requestReadData;

    logic [X_WIDTH-1:0]                        memoryXCoord;
    logic [Y_WIDTH-1:0]                        memoryYCoord;
    logic                                      memoryReadRequest;
    logic                                      memoryWriteRequest;
    logic [DATA_WIDTH-1:0]                     memoryWriteData;
    logic [DATA_WIDTH-1:0]                     memoryReadData;
    logic                                      memoryReadComplete;
    logic                                      memoryWriteComplete;

    modport slave (
        input  requestValid, requestWrite, requestXCoord, requestYCoord, requestWriteData,
        output requestDone, requestError, requestReadData,
        output memoryXCoord, memoryYCoord, memoryReadRequest, memoryWriteRequest, memoryWriteData,
        input  memoryReadData, memoryReadComplete, memoryWriteComplete
    );

    modport master (
        output requestValid, requestWrite, requestXCoord, requestYCoord, requestWriteData,
        input  requestDone, requestError, requestReadData,
        input  memoryXCoord, memoryYCoord, memoryReadRequest, memoryWriteRequest, memoryWriteData,
        output memoryReadData, memoryReadComplete, memoryWriteComplete
    );

endinterface

`default_nettype wire

// File: rtl/memory_port_arbiter_round_robin_picker.sv
// ============================================================================
// round_robin_picker : first valid client after the last grant, wrapping
// Revision: 1.0
// ============================================================================
`default_nettype none

module round_robin_picker #(
    parameter int NUM_REQUESTERS = 2,
    parameter int GRANT_W        = 1
) (
    input  wire logic [NUM_REQUESTERS-1:0] i_valid,
    input  wire logic [GRANT_W-1:0]        i_last_grant,
    output logic      [GRANT_W-1:0]        o_grant,
    output logic                           o_any_valid
);

    int w_idx;

    // Scan farthest-first so the closest valid client after i_last_grant wins.
    always_comb begin
        o_grant     = '0;
        o_any_valid = 1'b0;
        w_idx       = 0;
        for (int i = NUM_REQUESTERS; i >= 1; i--) begin
            w_idx = (int'(i_last_grant) + i) % NUM_REQUESTERS;
            if (i_valid[w_idx]) begin
                o_grant     = GRANT_W'(w_idx);
                o_any_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/memory_port_arbiter.sv
// ============================================================================
// memory_port_arbiter : round-robin sharing of the MemoryManager pixel port
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_port_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic             clock,
    input  wire logic             reset,
    memory_port_arbiter_if.slave  bus
);
    import memory_port_pkg::*;

    localparam int                GRANT_W    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int                WD_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [GRANT_W-1:0] LAST_INIT = GRANT_W'(NUM_REQUESTERS - 1);

    arb_state_e                r_state_q, w_state_d;
    logic [GRANT_W-1:0]        r_grant_q, w_grant_d;
    logic [GRANT_W-1:0]        r_last_q, w_last_d;
    logic                      r_write_q, w_write_d;
    logic [X_WIDTH-1:0]        r_x_q, w_x_d;
    logic [Y_WIDTH-1:0]        r_y_q, w_y_d;
    logic [DATA_WIDTH-1:0]     r_wdata_q, w_wdata_d;
    logic [DATA_WIDTH-1:0]     r_rdata_q, w_rdata_d;
    logic                      r_rd_req_q, w_rd_req_d;
    logic                      r_wr_req_q, w_wr_req_d;
    logic [NUM_REQUESTERS-1:0] r_done_q, w_done_d;
    logic                      r_err_q, w_err_d;
    logic [WD_W-1:0]           r_wd_q, w_wd_d;

    logic [GRANT_W-1:0]        w_pick;
    logic                      w_any;
    logic                      w_complete;

    round_robin_picker #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .GRANT_W        (GRANT_W)
    ) u_picker (
        .i_valid      (bus.requestValid),
        .i_last_grant (r_last_q),
        .o_grant      (w_pick),
        .o_any_valid  (w_any)
    );

    // A complete for the other operation is not ours and must not end the transaction.
    assign w_complete = r_write_q ? bus.memoryWriteComplete : bus.memoryReadComplete;

    always_comb begin
        w_state_d  = r_state_q;
        w_grant_d  = r_grant_q;
        w_last_d   = r_last_q;
        w_write_d  = r_write_q;
        w_x_d      = r_x_q;
        w_y_d      = r_y_q;
        w_wdata_d  = r_wdata_q;
        w_rdata_d  = r_rdata_q;
        w_rd_req_d = r_rd_req_q;
        w_wr_req_d = r_wr_req_q;
        w_done_d   = '0;
        w_err_d    = 1'b0;
        w_wd_d     = r_wd_q;

        case (r_state_q)
            IDLE: begin
                if (w_any) begin
                    w_grant_d  = w_pick;
                    w_write_d  = bus.requestWrite[w_pick];
                    w_x_d      = bus.requestXCoord[w_pick];
                    w_y_d      = bus.requestYCoord[w_pick];
                    w_wdata_d  = bus.requestWriteData[w_pick];
                    w_wr_req_d = bus.requestWrite[w_pick];
                    w_rd_req_d = ~bus.requestWrite[w_pick];
                    w_wd_d     = '0;
                    w_state_d  = BUSY;
                end
            end
            BUSY: begin
                if (w_complete) begin
                    w_rd_req_d          = 1'b0;
                    w_wr_req_d          = 1'b0;
                    w_done_d[r_grant_q] = 1'b1;
                    w_last_d            = r_grant_q;
                    w_state_d           = RECOVER;
                    if (!r_write_q) begin
                        w_rdata_d = bus.memoryReadData;
                    end
                end else if (r_wd_q == WD_LIMIT) begin
                    w_rd_req_d          = 1'b0;
                    w_wr_req_d          = 1'b0;
                    w_done_d[r_grant_q] = 1'b1;
                    w_err_d             = 1'b1;
                    w_last_d            = r_grant_q;
                    w_state_d           = RECOVER;
                end else begin
                    w_wd_d = r_wd_q + 1'b1;
                end
            end
            RECOVER: w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q  <= IDLE;
            r_grant_q  <= '0;
            r_last_q   <= LAST_INIT;
            r_write_q  <= 1'b0;
            r_x_q      <= '0;
            r_y_q      <= '0;
            r_wdata_q  <= '0;
            r_rdata_q  <= '0;
            r_rd_req_q <= 1'b0;
            r_wr_req_q <= 1'b0;
            r_done_q   <= '0;
            r_err_q    <= 1'b0;
            r_wd_q     <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_grant_q  <= w_grant_d;
            r_last_q   <= w_last_d;
            r_write_q  <= w_write_d;
            r_x_q      <= w_x_d;
            r_y_q      <= w_y_d;
            r_wdata_q  <= w_wdata_d;
            r_rdata_q  <= w_rdata_d;
            r_rd_req_q <= w_rd_req_d;
            r_wr_req_q <= w_wr_req_d;
            r_done_q   <= w_done_d;
            r_err_q    <= w_err_d;
            r_wd_q     <= w_wd_d;
        end
    end

    assign bus.memoryXCoord       = r_x_q;
    assign bus.memoryYCoord       = r_y_q;
    assign bus.memoryWriteData    = r_wdata_q;
    assign bus.memoryReadRequest  = r_rd_req_q;
    assign bus.memoryWriteRequest = r_wr_req_q;
    assign bus.requestDone        = r_done_q;
    assign bus.requestError       = r_err_q;
    assign bus.requestReadData    = r_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
// ============================================================================
// tb_memory_port_arbiter : directed checks against a small MemoryManager model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    memory_port_arbiter_if #(.NUM_REQUESTERS(2)) bus ();

    memory_port_arbiter #(
        .NUM_REQUESTERS (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // MemoryManager model: completes two cycles after seeing a request
    logic [7:0] ram [0:131071];
    logic [7:0] m_rd;
    logic       m_rc, m_wc;
    int         m_cnt;
    bit         model_en;
    logic [7:0] man_rd;
    logic       man_rc, man_wc;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_rc  <= 1'b0;
            m_wc  <= 1'b0;
            m_cnt <= 0;
        end else begin
            m_rc <= 1'b0;
            m_wc <= 1'b0;
            if (model_en && (bus.memoryReadRequest || bus.memoryWriteRequest) && !m_rc && !m_wc) begin
                if (m_cnt == 1) begin
                    m_cnt <= 0;
                    if (bus.memoryWriteRequest) begin
                        ram[{bus.memoryYCoord, bus.memoryXCoord}] <= bus.memoryWriteData;
                        m_wc <= 1'b1;
                    end else begin
                        m_rd <= ram[{bus.memoryYCoord, bus.memoryXCoord}];
                        m_rc <= 1'b1;
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_cnt <= 0;
            end
        end
    end

    assign bus.memoryReadData      = model_en ? m_rd : man_rd;
    assign bus.memoryReadComplete  = m_rc | man_rc;
    assign bus.memoryWriteComplete = m_wc | man_wc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int c, input bit wr, input logic [8:0] x, input logic [7:0] y,
                           input logic [7:0] d, output int lat, output logic [1:0] done_v,
                           output logic err_v, output bit op_ok, output bit addr_ok);
        @(negedge clock);
        bus.requestValid[c]     = 1'b1;
        bus.requestWrite[c]     = wr;
        bus.requestXCoord[c]    = x;
        bus.requestYCoord[c]    = y;
        bus.requestWriteData[c] = d;
        @(negedge clock);
        op_ok = wr ? (bus.memoryWriteRequest && !bus.memoryReadRequest)
                   : (bus.memoryReadRequest && !bus.memoryWriteRequest);
        addr_ok = 1'b1;
        // Changing the inputs after grant must not disturb the transaction.
        bus.requestXCoord[c]    = ~x;
        bus.requestYCoord[c]    = ~y;
        bus.requestWriteData[c] = ~d;
        bus.requestWrite[c]     = ~wr;
        lat = 0;
        while (bus.requestDone == 2'b00 && lat < 40) begin
            if (bus.memoryReadRequest || bus.memoryWriteRequest)
                addr_ok &= (bus.memoryXCoord == x) && (bus.memoryYCoord == y) &&
                           (bus.memoryWriteData == d);
            @(negedge clock);
            lat++;
        end
        done_v = bus.requestDone;
        err_v  = bus.requestError;
        bus.requestValid[c] = 1'b0;
    endtask

    typedef struct {
        int         c;
        bit         wr;
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] d;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         lat, ndone, cnt0, cnt1, last_cyc, guard;
        logic [1:0] done_v;
        logic       err_v;
        bit         op_ok, addr_ok, gap_bad, prev_done, bad;

        bus.requestValid = '0; bus.requestWrite = '0;
        bus.requestXCoord = '0; bus.requestYCoord = '0; bus.requestWriteData = '0;
        man_rd = 8'h00; man_rc = 1'b0; man_wc = 1'b0; model_en = 1'b1;

        vecs[0] = '{c: 0, wr: 1'b1, x: 9'd5,   y: 8'd7,   d: 8'hA5, exp_rd: 8'h00};
        vecs[1] = '{c: 0, wr: 1'b1, x: 9'd319, y: 8'd239, d: 8'h3C, exp_rd: 8'h00};
        vecs[2] = '{c: 1, wr: 1'b0, x: 9'd319, y: 8'd239, d: 8'h00, exp_rd: 8'h3C};
        vecs[3] = '{c: 1, wr: 1'b1, x: 9'd0,   y: 8'd0,   d: 8'h5A, exp_rd: 8'h3C};
        vecs[4] = '{c: 0, wr: 1'b0, x: 9'd0,   y: 8'd0,   d: 8'h00, exp_rd: 8'h5A};
        vecs[5] = '{c: 1, wr: 1'b0, x: 9'd5,   y: 8'd7,   d: 8'h00, exp_rd: 8'hA5};

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_rreq",  bus.memoryReadRequest, 0);
        chk("rst_wreq",  bus.memoryWriteRequest, 0);
        chk("rst_done",  bus.requestDone, 0);
        chk("rst_err",   bus.requestError, 0);
        chk("rst_rdata", bus.requestReadData, 0);
        chk("rst_x",     bus.memoryXCoord, 0);
        chk("rst_y",     bus.memoryYCoord, 0);
        chk("rst_wdata", bus.memoryWriteData, 0);
        reset = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].c, vecs[i].wr, vecs[i].x, vecs[i].y, vecs[i].d, lat, done_v, err_v, op_ok, addr_ok);
            chk($sformatf("v%0d_op", i), op_ok, 1);
            chk($sformatf("v%0d_addr", i), addr_ok, 1);
            chk($sformatf("v%0d_lat", i), lat, 3);
            chk($sformatf("v%0d_done", i), done_v, (vecs[i].c == 0) ? 2'b01 : 2'b10);
            chk($sformatf("v%0d_err", i), err_v, 0);
            chk($sformatf("v%0d_rdata", i), bus.requestReadData, vecs[i].exp_rd);
            if (vecs[i].wr)
                chk($sformatf("v%0d_ram", i), ram[{vecs[i].y, vecs[i].x}], vecs[i].d);
            @(negedge clock);
            chk($sformatf("v%0d_pulse", i), bus.requestDone, 0);
            chk($sformatf("v%0d_reqs", i), {bus.memoryReadRequest, bus.memoryWriteRequest}, 0);
        end

        // Both clients hold valid: grants alternate, one RECOVER gap, period 5
        @(negedge clock);
        bus.requestValid = 2'b11; bus.requestWrite = 2'b11;
        bus.requestXCoord[0] = 9'd100; bus.requestYCoord[0] = 8'd50; bus.requestWriteData[0] = 8'h11;
        bus.requestXCoord[1] = 9'd200; bus.requestYCoord[1] = 8'd60; bus.requestWriteData[1] = 8'h22;
        ndone = 0; cnt0 = 0; cnt1 = 0; gap_bad = 0; prev_done = 0; guard = 0; last_cyc = 0;
        while (ndone < 8 && guard < 200) begin
            @(negedge clock);
            guard++;
            if (prev_done && (bus.memoryReadRequest || bus.memoryWriteRequest)) gap_bad = 1;
            prev_done = (bus.requestDone != 2'b00);
            if (bus.requestDone != 2'b00) begin
                chk("rr_order", bus.requestDone, (ndone % 2 == 0) ? 2'b01 : 2'b10);
                if (ndone > 0) chk("rr_period", guard - last_cyc, 5);
                last_cyc = guard;
                if (bus.requestDone == 2'b01) cnt0++;
                else if (bus.requestDone == 2'b10) cnt1++;
                ndone++;
                if (ndone == 8) bus.requestValid = 2'b00;
            end
        end
        chk("rr_cnt0", cnt0, 4);
        chk("rr_cnt1", cnt1, 4);
        chk("rr_gap", gap_bad, 0);
        chk("rr_ram0", ram[{8'd50, 9'd100}], 8'h11);
        chk("rr_ram1", ram[{8'd60, 9'd200}], 8'h22);

        // Watchdog: no complete, abort 15 cycles after BUSY entry
        model_en = 1'b0;
        @(negedge clock);
        bus.requestValid[0] = 1'b1; bus.requestWrite[0] = 1'b0;
        bus.requestXCoord[0] = 9'd10; bus.requestYCoord[0] = 8'd10;
        @(negedge clock);
        chk("to_req_up", bus.memoryReadRequest, 1);
        lat = 0;
        while (bus.requestDone == 2'b00 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk("to_latency", lat, 15);
        chk("to_done", bus.requestDone, 2'b01);
        chk("to_err", bus.requestError, 1);
        chk("to_rdata_held", bus.requestReadData, 8'hA5);
        chk("to_req_drop", bus.memoryReadRequest, 0);
        bus.requestValid[0] = 1'b0;
        @(negedge clock);
        chk("to_err_clear", bus.requestError, 0);
        model_en = 1'b1;
        run_txn(0, 1'b0, 9'd0, 8'd0, 8'h00, lat, done_v, err_v, op_ok, addr_ok);
        chk("post_to_done", done_v, 2'b01);
        chk("post_to_err", err_v, 0);
        chk("post_to_rdata", bus.requestReadData, 8'h5A);

        // Spurious write complete during a read is ignored
        model_en = 1'b0;
        @(negedge clock);
        bus.requestValid[0] = 1'b1; bus.requestWrite[0] = 1'b0;
        bus.requestXCoord[0] = 9'd319; bus.requestYCoord[0] = 8'd239;
        @(negedge clock);
        man_wc = 1'b1;
        @(negedge clock);
        man_wc = 1'b0;
        chk("sp_no_done", bus.requestDone, 0);
        chk("sp_req_held", bus.memoryReadRequest, 1);
        @(negedge clock);
        man_rd = 8'hC3; man_rc = 1'b1;
        @(negedge clock);
        man_rc = 1'b0;
        chk("sp_done", bus.requestDone, 2'b01);
        chk("sp_err", bus.requestError, 0);
        chk("sp_rdata", bus.requestReadData, 8'hC3);
        chk("sp_req_drop", bus.memoryReadRequest, 0);
        bus.requestValid[0] = 1'b0;

        // Reset mid-BUSY cancels; client 0 wins first afterwards
        @(negedge clock);
        bus.requestValid[1] = 1'b1; bus.requestWrite[1] = 1'b1;
        bus.requestXCoord[1] = 9'd3; bus.requestYCoord[1] = 8'd4; bus.requestWriteData[1] = 8'h77;
        @(negedge clock);
        chk("mr_req_up", bus.memoryWriteRequest, 1);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        chk("mr_async_wreq", bus.memoryWriteRequest, 0);
        chk("mr_async_rreq", bus.memoryReadRequest, 0);
        chk("mr_async_done", bus.requestDone, 0);
        bus.requestValid = 2'b00;
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.requestDone != 2'b00) bad = 1;
        end
        chk("mr_no_done", bad, 0);
        reset = 1'b1;
        model_en = 1'b1;
        @(negedge clock);
        bus.requestValid = 2'b11; bus.requestWrite = 2'b11;
        bus.requestXCoord[0] = 9'd1; bus.requestYCoord[0] = 8'd1; bus.requestWriteData[0] = 8'h01;
        bus.requestXCoord[1] = 9'd2; bus.requestYCoord[1] = 8'd2; bus.requestWriteData[1] = 8'h02;
        guard = 0;
        while (bus.requestDone == 2'b00 && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        chk("mr_first_grant", bus.requestDone, 2'b01);
        bus.requestValid[0] = 1'b0;
        @(negedge clock);
        guard = 0;
        while (bus.requestDone == 2'b00 && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        chk("mr_second_grant", bus.requestDone, 2'b10);
        bus.requestValid = 2'b00;
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
